// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the nibble-serial ALU: op-codes, the
//               sequencer state encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_DEFAULT_WIDTH = 16;

    // Op-codes. Bit 2 selects ~b and doubles as the carry-in of nibble 0,
    // which turns ADD into SUB (a + ~b + 1).
    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_RSV  = 3'b011;
    localparam logic [2:0] c_OP_ANDN = 3'b100;
    localparam logic [2:0] c_OP_ORN  = 3'b101;
    localparam logic [2:0] c_OP_SUB  = 3'b110;
    localparam logic [2:0] c_OP_SLT  = 3'b111;

    // Sequencer state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Ops whose carry/overflow flags are meaningful
    function automatic logic is_arith(input logic [2:0] op);
        return (op == c_OP_ADD) || (op == c_OP_SUB) || (op == c_OP_SLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_nibble_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_nibble_seq_if
// Description : Request/response bundle of the nibble-serial ALU.
//               master: drives start/op/a/b, observes busy/done/result/flags.
//               slave : the ALU sequencer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_nibble_seq_if #(
    parameter int WIDTH = alu_pkg::c_DEFAULT_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/ALU4Bit.sv
`default_nettype none
// ============================================================================
// Module      : ALU4Bit
// Description : Combinational 4-bit ALU slice.
//               i_op[2] inverts b; i_op[1:0]: 00 AND, 01 OR, 10 ADD, 11 SLT
//               (outputs i_less in bit 0).
//   Ports : i_a, i_b (4b), i_cin, i_less, i_op (3b)
//           o_y (4b), o_cout, o_ovf, o_set (sum msb), o_g, o_p (group G/P)
// Revision    : 1.0 - initial release
// ============================================================================
module ALU4Bit (
    input  wire logic [3:0] i_a,
    input  wire logic [3:0] i_b,
    input  wire logic       i_cin,
    input  wire logic       i_less,
    input  wire logic [2:0] i_op,
    output logic      [3:0] o_y,
    output logic            o_cout,
    output logic            o_ovf,
    output logic            o_set,
    output logic            o_g,
    output logic            o_p
);
    logic [3:0] w_bb;
    logic [4:0] w_sum;
    logic [4:0] w_gen;
    logic       w_c3;

    assign w_bb  = i_op[2] ? ~i_b : i_b;
    assign w_sum = {1'b0, i_a} + {1'b0, w_bb} + {4'b0000, i_cin};
    assign w_gen = {1'b0, i_a} + {1'b0, w_bb};

    // Carry into bit 3 recovered from the sum bit: c3 = a3 ^ b3 ^ s3
    assign w_c3   = i_a[3] ^ w_bb[3] ^ w_sum[3];
    assign o_cout = w_sum[4];
    assign o_ovf  = w_c3 ^ w_sum[4];
    assign o_set  = w_sum[3];
    assign o_g    = w_gen[4];
    assign o_p    = &(i_a ^ w_bb);

    always_comb begin
        o_y = 4'h0;
        case (i_op[1:0])
            2'b00:   o_y = i_a & w_bb;
            2'b01:   o_y = i_a | w_bb;
            2'b10:   o_y = w_sum[3:0];
            default: o_y = {3'b000, i_less};
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_nibble_seq
// Description : WIDTH-bit ALU computed serially, one nibble per cycle, through
//               a single ALU4Bit slice. IDLE -> RUN (NIBBLES cycles) -> DONE.
//   Ports : clk, reset (sync, active-high)
//           bus (alu_nibble_seq_if.slave): start, op, a, b in;
//           busy, done, result, cout, overflow, zero out (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_nibble_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = c_DEFAULT_WIDTH,
    parameter int NIBBLES = WIDTH / 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    alu_nibble_seq_if.slave   bus
);
    localparam int             c_CW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NIBBLES - 1);

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;       // shifts right one nibble per RUN cycle
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_carry;
    logic [WIDTH-1:0] r_shadow;  // nibbles enter at the top, shift down
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_overflow;
    logic             r_zero;

    logic [2:0]       w_slice_op;
    logic [3:0]       w_y;
    logic             w_cout;
    logic             w_ovf;
    logic             w_unused_set;
    logic             w_unused_g;
    logic             w_unused_p;
    logic [WIDTH-1:0] w_final;
    logic             w_arith;

    // SLT is carried out as a subtraction; its result is formed at the end
    assign w_slice_op = (r_op == c_OP_SLT) ? c_OP_SUB : r_op;

    ALU4Bit u_slice (
        .i_a    (r_a[3:0]),
        .i_b    (r_b[3:0]),
        .i_cin  (r_carry),
        .i_less (1'b0),
        .i_op   (w_slice_op),
        .o_y    (w_y),
        .o_cout (w_cout),
        .o_ovf  (w_ovf),
        .o_set  (w_unused_set),
        .o_g    (w_unused_g),
        .o_p    (w_unused_p)
    );

    assign w_arith = is_arith(r_op);

    // Final result as it will be after the top nibble is captured
    always_comb begin
        w_final = {w_y, r_shadow[WIDTH-1:4]};
        if (r_op == c_OP_SLT) begin
            w_final = {{(WIDTH-1){1'b0}}, w_y[3] ^ w_ovf};
        end else if (r_op == c_OP_RSV) begin
            w_final = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= c_OP_AND;
            r_carry    <= 1'b0;
            r_shadow   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    r_carry  <= w_cout;
                    r_a      <= r_a >> 4;
                    r_b      <= r_b >> 4;
                    r_shadow <= {w_y, r_shadow[WIDTH-1:4]};
                    r_cnt    <= r_cnt + c_CW'(1);
                    if (r_cnt == c_LAST) begin
                        r_state    <= c_ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_result   <= w_final;
                        r_cout     <= w_arith & w_cout;
                        r_overflow <= w_arith & w_ovf;
                        r_zero     <= (w_final == '0);
                    end
                end
                default: begin
                    // IDLE and DONE are both ready states
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= c_ST_RUN;
                        r_busy  <= 1'b1;
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_op    <= bus.op;
                        r_carry <= bus.op[2];
                        r_cnt   <= '0;
                    end else begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_overflow;
    assign bus.zero     = r_zero;

endmodule
`default_nettype wire
